// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS pipeline front end.
//   DEFAULT_RESET_PC   : byte address fetched first after reset
//   DEFAULT_IMEM_DEPTH : instruction-memory size in words
//   IMEM_ADDR_W        : width of the instruction-memory word address
//   NOP                : encoding used for pipeline bubbles (sll $0,$0,0)
//   fetch_state_t      : fetch-stage FSM states
//   ifid_t             : IF/ID pipeline register record
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
  localparam int          DEFAULT_IMEM_DEPTH = 512;
  localparam int          IMEM_ADDR_W        = 9;
  localparam logic [31:0] NOP                = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // A bubble carries no PC information, so downstream stages can never
  // mistake it for a real instruction's link address.
  localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc_plus4: 32'h0000_0000, valid: 1'b0};

endpackage

// File: rtl/if_pc_select.sv
// if_pc_select
// Combinational next-PC selection and fetch-window check for the IF stage.
// Ports:
//   pc            in  32  current fetch PC
//   br_taken      in  1   conditional branch taken (highest priority)
//   br_target     in  32  branch target byte address
//   jump          in  1   J/JAL resolved
//   jump_target   in  32  J/JAL target byte address
//   jr            in  1   JR resolved (lowest priority)
//   jr_target     in  32  JR target byte address
//   next_pc       out 32  selected redirect target, or pc+4 when none
//   redirect      out 1   any redirect request is present
//   out_of_window out 1   pc lies outside the instruction memory or is misaligned
module if_pc_select
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        out_of_window
);

  // The window bounds are kept 33 bits wide so a window ending exactly at
  // the top of the 32-bit address space does not wrap to zero.
  localparam logic [32:0] WINDOW_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WINDOW_HI = WINDOW_LO + (33'(IMEM_DEPTH) * 33'd4);

  logic [31:0] seq_pc;

  assign seq_pc = pc + 32'd4;

  // Redirect priority: branch over jump over jr. Targets pass through
  // untouched; a misaligned target is caught by the window check next cycle.
  always_comb begin
    redirect = br_taken | jump | jr;
    next_pc  = seq_pc;
    if (br_taken) begin
      next_pc = br_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (jr) begin
      next_pc = jr_target;
    end
  end

  // Check the PC currently being fetched, not the one about to be loaded.
  always_comb begin
    out_of_window = 1'b0;
    if ({1'b0, pc} < WINDOW_LO) begin
      out_of_window = 1'b1;
    end
    if ({1'b0, pc} >= WINDOW_HI) begin
      out_of_window = 1'b1;
    end
    if (pc[1:0] != 2'b00) begin
      out_of_window = 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives
// the combinational instruction memory and loads the IF/ID register.
// Redirects squash the instruction fetched in the same cycle (no delay slots).
// Ports:
//   clk           in  1   pipeline clock, rising edge
//   rst_n         in  1   asynchronous active-low reset
//   im_addr       out 9   instruction-memory word address (pc[10:2])
//   im_instr      in  32  instruction returned for im_addr
//   stall         in  1   hold PC, IF/ID and fetch_count
//   br_taken      in  1   ID: conditional branch taken
//   br_target     in  32  ID: branch target
//   jump          in  1   ID: J/JAL resolved
//   jump_target   in  32  ID: J/JAL target
//   jr            in  1   ID: JR resolved
//   jr_target     in  32  ID: JR target (forwarded rs)
//   ifid_instr    out 32  IF/ID instruction
//   ifid_pc_plus4 out 32  IF/ID PC+4 of that instruction
//   ifid_valid    out 1   IF/ID holds a real instruction
//   pc            out 32  current fetch PC
//   fault         out 1   sticky: PC left the legal window
//   fetch_count   out 32  valid instructions loaded into IF/ID
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [IMEM_ADDR_W-1:0] im_addr,
  input  logic [31:0]            im_instr,
  input  logic                   stall,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  input  logic                   jr,
  input  logic [31:0]            jr_target,
  output logic [31:0]            ifid_instr,
  output logic [31:0]            ifid_pc_plus4,
  output logic                   ifid_valid,
  output logic [31:0]            pc,
  output logic                   fault,
  output logic [31:0]            fetch_count
);

  fetch_state_t state;
  ifid_t        ifid;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         out_of_window;
  logic [31:0]  seq_pc_plus4;

  if_pc_select #(
    .RESET_PC   (RESET_PC),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_pc_select (
    .pc            (pc),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .out_of_window (out_of_window)
  );

  assign seq_pc_plus4 = pc + 32'd4;
  assign im_addr      = pc[IMEM_ADDR_W+1:2];

  assign ifid_instr    = ifid.instr;
  assign ifid_pc_plus4 = ifid.pc_plus4;
  assign ifid_valid    = ifid.valid;

  // Fetch FSM together with the PC, IF/ID and fetch_count registers.
  // In RUN an illegal PC outranks everything, including stall, so a bad
  // PC can never be latched into IF/ID. Stall freezes the whole stage and
  // ignores redirects because ID re-presents them once the stall clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ifid        <= IFID_BUBBLE;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          ifid  <= IFID_BUBBLE;
          state <= RUN;
        end
        RUN: begin
          if (out_of_window) begin
            ifid  <= IFID_BUBBLE;
            fault <= 1'b1;
            state <= FAULT;
          end else if (!stall) begin
            pc <= next_pc;
            if (redirect) begin
              ifid <= IFID_BUBBLE;
            end else begin
              ifid        <= '{instr: im_instr, pc_plus4: seq_pc_plus4, valid: 1'b1};
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        FAULT: begin
          ifid  <= IFID_BUBBLE;
          fault <= 1'b1;
        end
        default: begin
          ifid  <= IFID_BUBBLE;
          fault <= 1'b1;
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
// Self-checking bench for if_fetch_stage: directed scenarios followed by a
// randomized stall/redirect phase, all compared against a behavioural model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam int          IMEM_DEPTH = 512;
  localparam logic [31:0] WINDOW_END = RESET_PC + 32'(IMEM_DEPTH * 4);

  logic        clk;
  logic        rst_n;
  logic [8:0]  im_addr;
  logic [31:0] im_instr;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] pc;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] rom [IMEM_DEPTH];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_count;
  logic        m_boot;

  if_fetch_stage #(
    .RESET_PC   (RESET_PC),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .im_addr       (im_addr),
    .im_instr      (im_instr),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .pc            (pc),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  // Program ROM answers combinationally for whatever word is addressed.
  assign im_instr = rom[im_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".pc"}, pc, m_pc);
    checkValue({tag, ".im_addr"}, 32'(im_addr), (m_pc - RESET_PC) / 4 % IMEM_DEPTH);
    checkValue({tag, ".ifid_instr"}, ifid_instr, m_instr);
    checkValue({tag, ".ifid_pc_plus4"}, ifid_pc_plus4, m_pp4);
    checkValue({tag, ".ifid_valid"}, 32'(ifid_valid), 32'(m_valid));
    checkValue({tag, ".fault"}, 32'(fault), 32'(m_fault));
    checkValue({tag, ".fetch_count"}, fetch_count, m_count);
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt,
                               input logic r, input logic [31:0] rt);
    stall       = s;
    br_taken    = b;
    br_target   = bt;
    jump        = j;
    jump_target = jt;
    jr          = r;
    jr_target   = rt;
  endtask

  task automatic modelReset();
    m_pc    = RESET_PC;
    m_instr = 32'h0;
    m_pp4   = 32'h0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    m_count = 32'h0;
    m_boot  = 1'b1;
  endtask

  task automatic bubble();
    m_instr = 32'h0;
    m_pp4   = 32'h0;
    m_valid = 1'b0;
  endtask

  // One clock of the architectural behaviour, then compare everything.
  task automatic tick(input string tag);
    if (m_boot) begin
      m_boot = 1'b0;
      bubble();
    end else if (m_fault) begin
      bubble();
    end else if (m_pc < RESET_PC || m_pc >= WINDOW_END || m_pc % 4 != 0) begin
      m_fault = 1'b1;
      bubble();
    end else if (stall) begin
      // everything holds
    end else if (br_taken) begin
      m_pc = br_target;
      bubble();
    end else if (jump) begin
      m_pc = jump_target;
      bubble();
    end else if (jr) begin
      m_pc = jr_target;
      bubble();
    end else begin
      m_instr = rom[(m_pc - RESET_PC) / 4];
      m_pp4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Reset asserted between clock edges must clear the stage immediately.
  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] randTarget();
    return RESET_PC + ($urandom_range(0, IMEM_DEPTH - 1) * 4);
  endfunction

  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h8d10_0000;

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #12;
    checkOutput("reset");
    rst_n = 1'b1;

    // Boot bubble, then the first two program words.
    tick("boot");
    checkValue("boot_valid", 32'(ifid_valid), 32'd0);
    tick("first_fetch");
    checkValue("first_valid", 32'(ifid_valid), 32'd1);
    checkValue("first_instr", ifid_instr, 32'h0000_0000);
    checkValue("first_pp4", ifid_pc_plus4, 32'h0040_0004);
    tick("second_fetch");
    checkValue("second_instr", ifid_instr, 32'h8d10_0000);

    for (int i = 0; i < 8; i++) tick("seq");
    checkValue("seq_count", fetch_count, 32'd10);
    checkValue("seq_pc", pc, 32'h0040_0028);

    // Move to 0x14, then jump from there to 0x40.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0040_0014);
    tick("jr_to_14");
    applyStimulus(0, 0, 0, 1, 32'h0040_0040, 0, 0);
    tick("jump");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkValue("jump_bubble", 32'(ifid_valid), 32'd0);
    checkValue("jump_im_addr", 32'(im_addr), 32'd16);
    tick("jump_target");
    checkValue("jump_pp4", ifid_pc_plus4, 32'h0040_0044);

    // Stall beats a simultaneous branch for three cycles.
    applyStimulus(1, 1, 32'h0040_0100, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("stall");
    checkValue("stall_pc", pc, 32'h0040_0044);
    checkValue("stall_count", fetch_count, 32'd11);
    applyStimulus(0, 1, 32'h0040_0100, 0, 0, 0, 0);
    tick("stall_release");
    checkValue("release_pc", pc, 32'h0040_0100);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick("after_branch");

    // All three redirects: branch wins.
    applyStimulus(0, 1, 32'h0040_0200, 1, 32'h0040_0300, 1, 32'h0040_0400);
    tick("priority");
    checkValue("priority_pc", pc, 32'h0040_0200);
    applyStimulus(0, 0, 0, 1, 32'h0040_0300, 1, 32'h0040_0400);
    tick("priority_jump");
    checkValue("priority_jump_pc", pc, 32'h0040_0300);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Randomized stall / redirect mix, all targets inside the window.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 10, randTarget(),
                    $urandom_range(0, 99) < 10, randTarget(),
                    $urandom_range(0, 99) < 10, randTarget());
      tick("random");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick("random_drain");

    // JR one past the window end.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h0040_0800);
    tick("jr_oow");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick("fault_entry");
    checkValue("fault_set", 32'(fault), 32'd1);
    tick("fault_hold");
    checkValue("fault_valid", 32'(ifid_valid), 32'd0);
    checkValue("fault_pc", pc, 32'h0040_0800);
    pulseReset("fault_clear");
    checkValue("fault_cleared", 32'(fault), 32'd0);

    // Misaligned target faults too.
    tick("boot2");
    applyStimulus(1'b0, 1'b1, 32'h0040_0002, 1'b0, 32'h0, 1'b0, 32'h0);
    tick("misalign_redirect");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick("misalign_fault");
    checkValue("misalign_fault_set", 32'(fault), 32'd1);
    pulseReset("misalign_clear");

    // Target just below the window.
    tick("boot3");
    applyStimulus(0, 0, 0, 1, 32'h003F_FFFC, 0, 0);
    tick("below_redirect");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick("below_fault");
    checkValue("below_fault_set", 32'(fault), 32'd1);
    pulseReset("below_clear");
    tick("boot4");
    tick("refetch");
    checkValue("refetch_pp4", ifid_pc_plus4, 32'h0040_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
